// File: rtl/regfile_write_arbiter_pkg.sv
// Shared defaults for the execute/write-back stages and small sizing helpers.
package regfile_write_arbiter_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_NREQ  = 4;
  localparam int unsigned DEF_NREG  = 32;
  localparam int unsigned DEF_ADDRW = 5;

  // Index width that stays legal for a single-entry arbiter.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant starting at ptr; ptr moves past the winner on advance.
module rr_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned N    = DEF_NREQ,
  parameter int unsigned IDXW = idx_width(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            advance,
  output logic [N-1:0]    grant,
  output logic [IDXW-1:0] grant_idx
);

  logic [IDXW-1:0] ptr_q, ptr_d;

  always_comb begin
    logic        found;
    int unsigned idx;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(ptr_q) + k) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDXW'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = (grant_idx == IDXW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port among NREQ producers with a registered
// write port and a busy scoreboard (set at alloc, cleared at write-back).
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned NREQ  = DEF_NREQ,
  parameter int unsigned NREG  = DEF_NREG,
  parameter int unsigned ADDRW = DEF_ADDRW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*ADDRW-1:0] req_addr,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  wr_en,
  output logic [ADDRW-1:0]      wr_addr,
  output logic [WIDTH-1:0]      wr_data,
  input  logic                  alloc_en,
  input  logic [ADDRW-1:0]      alloc_addr,
  output logic [NREG-1:0]       busy,
  output logic                  err
);

  localparam int unsigned IDXW = idx_width(NREQ);

  logic [NREQ-1:0]  grant;
  logic [IDXW-1:0]  grant_idx;
  logic             hs;
  logic [ADDRW-1:0] sel_addr;
  logic [WIDTH-1:0] sel_data;

  logic             wr_en_q, wr_en_d;
  logic [ADDRW-1:0] wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0] wr_data_q, wr_data_d;
  logic [NREG-1:0]  busy_q, busy_d;
  logic             err_q, err_d;

  rr_arbiter #(
    .N    (NREQ),
    .IDXW (IDXW)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .advance   (hs),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Grant is a subset of req_valid, so any grant outside reset is a handshake.
  assign req_ready = rst ? '0 : grant;
  assign hs        = |req_ready;

  always_comb begin
    int unsigned gi;
    gi       = 32'(grant_idx);
    sel_addr = req_addr[gi*ADDRW +: ADDRW];
    sel_data = req_data[gi*WIDTH +: WIDTH];
  end

  always_comb begin
    wr_en_d   = hs && (sel_addr != '0);
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    busy_d    = busy_q;
    err_d     = err_q;
    if (hs) begin
      wr_addr_d        = sel_addr;
      wr_data_d        = sel_data;
      busy_d[sel_addr] = 1'b0;
      if ((sel_addr != '0) && !busy_q[sel_addr] &&
          !(alloc_en && (alloc_addr == sel_addr))) begin
        err_d = 1'b1;
      end
    end
    // Alloc after clear so a same-cycle alloc of the written register wins.
    if (alloc_en) begin
      busy_d[alloc_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;
  assign err     = err_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: reset, single write, round-robin, wrap, scoreboard, r0.
module tb_regfile_write_arbiter;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned NREQ  = 4;
  localparam int unsigned NREG  = 32;
  localparam int unsigned ADDRW = 5;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*ADDRW-1:0] req_addr;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  wr_en;
  logic [ADDRW-1:0]      wr_addr;
  logic [WIDTH-1:0]      wr_data;
  logic                  alloc_en;
  logic [ADDRW-1:0]      alloc_addr;
  logic [NREG-1:0]       busy;
  logic                  err;

  int checks = 0;
  int errors = 0;

  regfile_write_arbiter #(
    .WIDTH (WIDTH),
    .NREQ  (NREQ),
    .NREG  (NREG),
    .ADDRW (ADDRW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .busy       (busy),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_valid  = '0;
    req_addr   = '0;
    req_data   = '0;
    alloc_en   = 1'b0;
    alloc_addr = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      req_addr[i*ADDRW +: ADDRW] = ADDRW'(i + 1);
      req_data[i*WIDTH +: WIDTH] = WIDTH'(32'hA0 + i);
    end
    alloc_en = 1'b0;
    alloc_addr = '0;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++; $display("FAIL reset_ready: got %b expected 0000", req_ready);
    end
    step();
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++; $display("FAIL reset_ready2: got %b expected 0000", req_ready);
    end
    rst = 1'b0;
    req_valid = '0;
    checks++;
    if (wr_en !== 1'b0 || busy !== '0 || err !== 1'b0) begin
      errors++; $display("FAIL reset_state: wr_en=%b busy=%h err=%b expected 0/0/0", wr_en, busy, err);
    end
    step();
    checks++;
    if (wr_en !== 1'b0 || busy !== '0 || err !== 1'b0) begin
      errors++; $display("FAIL post_reset: wr_en=%b busy=%h err=%b expected 0/0/0", wr_en, busy, err);
    end
  endtask

  task automatic test_single();
    do_reset();
    alloc_en   = 1'b1;
    alloc_addr = 5'd5;
    step();
    alloc_en = 1'b0;
    checks++;
    if (busy !== 32'h0000_0020) begin
      errors++; $display("FAIL alloc5: busy=%h expected 00000020", busy);
    end
    req_valid                  = 4'b0100;
    req_addr[2*ADDRW +: ADDRW] = 5'd5;
    req_data[2*WIDTH +: WIDTH] = 32'hDEADBEEF;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++; $display("FAIL single_ready: got %b expected 0100", req_ready);
    end
    step();
    req_valid = '0;
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 5'd5 || wr_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL single_write: en=%b addr=%0d data=%h expected 1/5/deadbeef", wr_en, wr_addr, wr_data);
    end
    checks++;
    if (busy !== '0 || err !== 1'b0) begin
      errors++; $display("FAIL single_busy: busy=%h err=%b expected 0/0", busy, err);
    end
    step();
    checks++;
    if (wr_en !== 1'b0 || wr_addr !== 5'd5 || wr_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL single_hold: en=%b addr=%0d data=%h expected 0/5/deadbeef", wr_en, wr_addr, wr_data);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_ready;
    do_reset();
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      req_addr[i*ADDRW +: ADDRW] = ADDRW'(10 + i);
      req_data[i*WIDTH +: WIDTH] = WIDTH'(32'h1000 + i);
    end
    for (int c = 0; c < 8; c++) begin
      exp_ready = 4'b0001 << (c % 4);
      #1;
      checks++;
      if (req_ready !== exp_ready) begin
        errors++; $display("FAIL rr_grant%0d: got %b expected %b", c, req_ready, exp_ready);
      end
      step();
      checks++;
      if (wr_en !== 1'b1 || wr_addr !== ADDRW'(10 + c % 4) || wr_data !== WIDTH'(32'h1000 + c % 4)) begin
        errors++; $display("FAIL rr_write%0d: en=%b addr=%0d data=%h expected 1/%0d/%h",
                           c, wr_en, wr_addr, wr_data, 10 + c % 4, 32'h1000 + c % 4);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_wrap();
    logic [3:0] exp_ready [3];
    exp_ready[0] = 4'b0001;
    exp_ready[1] = 4'b0010;
    exp_ready[2] = 4'b0001;
    do_reset();
    req_valid                  = 4'b0100;
    req_addr[2*ADDRW +: ADDRW] = 5'd3;
    step();
    req_valid                  = 4'b0011;
    req_addr[0*ADDRW +: ADDRW] = 5'd20;
    req_addr[1*ADDRW +: ADDRW] = 5'd21;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (req_ready !== exp_ready[c]) begin
        errors++; $display("FAIL wrap_grant%0d: got %b expected %b", c, req_ready, exp_ready[c]);
      end
      step();
      checks++;
      if (wr_addr !== ((c == 1) ? 5'd21 : 5'd20)) begin
        errors++; $display("FAIL wrap_addr%0d: got %0d expected %0d", c, wr_addr, (c == 1) ? 21 : 20);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_alloc_clear();
    do_reset();
    req_valid                  = 4'b0010;
    req_addr[1*ADDRW +: ADDRW] = 5'd7;
    req_data[1*WIDTH +: WIDTH] = 32'h77;
    alloc_en                   = 1'b1;
    alloc_addr                 = 5'd7;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++; $display("FAIL ac_ready: got %b expected 0010", req_ready);
    end
    step();
    alloc_en = 1'b0;
    checks++;
    if (busy !== 32'h0000_0080 || err !== 1'b0 || wr_en !== 1'b1) begin
      errors++; $display("FAIL ac_busy7: busy=%h err=%b en=%b expected 00000080/0/1", busy, err, wr_en);
    end
    req_valid                  = 4'b0010;
    req_addr[1*ADDRW +: ADDRW] = 5'd9;
    step();
    req_valid = '0;
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL err_set: got %b expected 1", err);
    end
    step();
    step();
    checks++;
    if (err !== 1'b1 || busy !== 32'h0000_0080) begin
      errors++; $display("FAIL err_sticky: err=%b busy=%h expected 1/00000080", err, busy);
    end
    do_reset();
    checks++;
    if (err !== 1'b0 || busy !== '0) begin
      errors++; $display("FAIL err_reset: err=%b busy=%h expected 0/0", err, busy);
    end
  endtask

  task automatic test_zero();
    do_reset();
    alloc_en   = 1'b1;
    alloc_addr = 5'd0;
    step();
    alloc_en = 1'b0;
    checks++;
    if (busy !== '0) begin
      errors++; $display("FAIL alloc0: busy=%h expected 0", busy);
    end
    req_valid                  = 4'b1000;
    req_addr[3*ADDRW +: ADDRW] = 5'd0;
    req_data[3*WIDTH +: WIDTH] = 32'h1234;
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++; $display("FAIL zero_ready: got %b expected 1000", req_ready);
    end
    step();
    req_valid = '0;
    checks++;
    if (wr_en !== 1'b0 || busy[0] !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL zero_write: en=%b busy0=%b err=%b expected 0/0/0", wr_en, busy[0], err);
    end
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_alloc_clear();
    test_zero();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
